// File: rtl/img_pkg.sv
// Shared pixel-path definitions for the image encoder/decoder pair.
package img_pkg;

  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t PIX_MAX = 8'hFF;

  typedef enum logic [1:0] {
    MODE_BRIGHT = 2'b00,
    MODE_DARK   = 2'b01,
    MODE_THRESH = 2'b10,
    MODE_INV    = 2'b11
  } mode_e;

endpackage

// File: rtl/img_decr_stream_if.sv
// Valid/ready pixel stream bundle for img_decr_stream: source side (with per-frame config) and sink side.
interface img_decr_stream_if;
  import img_pkg::*;

  logic       in_valid;
  logic       in_ready;
  pix_t       in_byte;
  logic       in_sof;
  logic [1:0] select;
  pix_t       value;
  pix_t       threshold;
  logic       out_valid;
  logic       out_ready;
  pix_t       out_byte;
  logic       out_sof;
  logic       out_eof;

  modport master (
    output in_valid, in_byte, in_sof, select, value, threshold, out_ready,
    input  in_ready, out_valid, out_byte, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_byte, in_sof, select, value, threshold, out_ready,
    output in_ready, out_valid, out_byte, out_sof, out_eof
  );

endinterface

// File: rtl/img_pix_inv.sv
// Combinational per-pixel inverse transform; sat flags a clamped brighten/darken result.
module img_pix_inv
  import img_pkg::*;
(
  input  mode_e sel,
  input  pix_t  val,
  input  pix_t  thr,
  input  pix_t  in_byte,
  output pix_t  out_byte,
  output logic  sat
);

  always_comb begin
    out_byte = '0;
    sat      = 1'b0;
    case (sel)
      MODE_BRIGHT: begin
        if (in_byte < val) begin
          out_byte = '0;
          sat      = 1'b1;
        end else begin
          out_byte = in_byte - val;
        end
      end
      MODE_DARK: begin
        if (in_byte > (PIX_MAX - val)) begin
          out_byte = PIX_MAX;
          sat      = 1'b1;
        end else begin
          out_byte = in_byte + val;
        end
      end
      MODE_THRESH: out_byte = (in_byte == PIX_MAX) ? thr : '0;
      MODE_INV:    out_byte = PIX_MAX - in_byte;
      default:     out_byte = '0;
    endcase
  end

endmodule

// File: rtl/img_decr_stream.sv
// Streaming pixel decoder: single registered stage with backpressure, per-frame config latch and framing checks.
// Optional per-frame saturated-pixel statistics are built when IMG_DECR_SAT_STATS_EN is defined.
module img_decr_stream
  import img_pkg::*;
#(
  parameter int FRAME_PIXELS = 4096,
  parameter int CNT_W        = 12
)
(
  input  logic                clk,
  input  logic                rst,
  img_decr_stream_if.slave    px,
  output logic                frame_err,
  output logic [15:0]         sat_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            sel_q, sel_eff;
  pix_t             value_q, thr_q, val_eff, thr_eff;
  pix_t             dec_byte;
  logic             pix_sat;

  logic             out_valid_q, out_sof_q, out_eof_q, err_q;
  pix_t             out_byte_q;

  logic             accept, at_last, at_first, beat_err;

  assign accept       = px.in_valid && (!out_valid_q || px.out_ready);
  assign px.in_ready  = !out_valid_q || px.out_ready;
  assign px.out_valid = out_valid_q;
  assign px.out_byte  = out_byte_q;
  assign px.out_sof   = out_sof_q;
  assign px.out_eof   = out_eof_q;
  assign frame_err    = err_q;

  // A sof beat is decoded with the config arriving alongside it, not the held one.
  always_comb begin
    sel_eff  = sel_q;
    val_eff  = value_q;
    thr_eff  = thr_q;
    at_last  = (cnt_q == CNT_LAST);
    at_first = (cnt_q == '0);
    beat_err = 1'b0;
    cnt_d    = cnt_q;
    if (px.in_sof) begin
      sel_eff  = mode_e'(px.select);
      val_eff  = px.value;
      thr_eff  = px.threshold;
      beat_err = !at_first;
      cnt_d    = CNT_ONE;
    end else begin
      beat_err = at_first;
      cnt_d    = at_last ? '0 : cnt_q + CNT_ONE;
    end
  end

  img_pix_inv u_pix_inv (
    .sel      (sel_eff),
    .val      (val_eff),
    .thr      (thr_eff),
    .in_byte  (px.in_byte),
    .out_byte (dec_byte),
    .sat      (pix_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= MODE_INV;
      value_q <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      cnt_q <= cnt_d;
      if (px.in_sof) begin
        sel_q   <= mode_e'(px.select);
        value_q <= px.value;
        thr_q   <= px.threshold;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= accept && beat_err;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= dec_byte;
        out_sof_q   <= px.in_sof;
        out_eof_q   <= !px.in_sof && at_last;
      end else if (px.out_ready) begin
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end
    end
  end

`ifdef IMG_DECR_SAT_STATS_EN
  logic [15:0] sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= '0;
    end else if (accept) begin
      if (px.in_sof) begin
        sat_q <= {15'd0, pix_sat};
      end else if (pix_sat && (sat_q != '1)) begin
        sat_q <= sat_q + 16'd1;
      end
    end
  end

  assign sat_count = sat_q;
`else
  logic unused_sat;
  assign unused_sat = pix_sat;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_img_decr_stream.sv
// Self-checking bench for img_decr_stream: vector table, directed corner sequences and randomized traffic vs a reference model.
module tb_img_decr_stream;
  import img_pkg::*;

  localparam int FP = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_err;
  logic [15:0] sat_count;

  img_decr_stream_if px ();

  img_decr_stream #(.FRAME_PIXELS(FP), .CNT_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .px        (px),
    .frame_err (frame_err),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_cnt, m_sel, m_val, m_thr, m_byte, m_satc;
  bit m_valid, m_sof, m_eof, m_err;

  typedef struct {
    bit sof;
    int sel, val, thr, b;
    int exp_out;
    bit exp_sof;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decode(input int sel, input int val, input int thr, input int b,
                                 output int r, output bit sat);
    sat = 0;
    case (sel)
      0: begin r = b - val; if (r < 0)   begin r = 0;   sat = 1; end end
      1: begin r = b + val; if (r > 255) begin r = 255; sat = 1; end end
      2: r = (b == 255) ? thr : 0;
      default: r = 255 - b;
    endcase
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_sel = 3; m_val = 0; m_thr = 0; m_byte = 0; m_satc = 0;
    m_valid = 0; m_sof = 0; m_eof = 0; m_err = 0;
  endfunction

  task automatic drive(input bit v, input bit sof, input int sel, input int val,
                       input int thr, input int b, input bit ordy);
    px.in_valid  = v;
    px.in_sof    = sof;
    px.select    = 2'(sel);
    px.value     = 8'(val);
    px.threshold = 8'(thr);
    px.in_byte   = 8'(b);
    px.out_ready = ordy;
  endtask

  // One clock: model the handshake for the driven inputs, then compare outputs after the edge.
  task automatic cycle();
    bit acc, s;
    int r;
    #1;
    chk("in_ready", px.in_ready, !m_valid || px.out_ready);
    acc = px.in_valid && (!m_valid || px.out_ready);
    if (acc) begin
      m_err = px.in_sof ? (m_cnt != 0) : (m_cnt == 0);
      if (px.in_sof) begin
        m_sel = int'(px.select); m_val = int'(px.value); m_thr = int'(px.threshold);
      end
      decode(m_sel, m_val, m_thr, int'(px.in_byte), r, s);
`ifdef IMG_DECR_SAT_STATS_EN
      if (px.in_sof) m_satc = s ? 1 : 0;
      else if (s && m_satc < 65535) m_satc++;
`endif
      m_eof   = (m_cnt == FP - 1);
      m_sof   = px.in_sof;
      m_cnt   = px.in_sof ? 1 : (m_cnt + 1) % FP;
      m_byte  = r;
      m_valid = 1;
    end else begin
      m_err = 0;
      if (px.out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", px.out_valid, m_valid);
    if (m_valid) begin
      chk("out_byte", px.out_byte, m_byte);
      chk("out_sof", px.out_sof, m_sof);
      chk("out_eof", px.out_eof, m_eof);
    end
    chk("frame_err", frame_err, m_err);
    chk("sat_count", sat_count, m_satc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, px.out_valid, 0);
    chk({tag, "_byte"}, px.out_byte, 0);
    chk({tag, "_sof"}, px.out_sof, 0);
    chk({tag, "_eof"}, px.out_eof, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_sat"}, sat_count, 0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst");
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int eofs, errs, n, held;
    bit found;

    tbl[0] = '{1, 0, 8'h20, 0,     8'h50, 8'h30, 1};
    tbl[1] = '{0, 0, 0,     0,     8'h10, 8'h00, 0};
    tbl[2] = '{1, 1, 8'h40, 0,     8'hF0, 8'hFF, 1};
    tbl[3] = '{0, 0, 0,     0,     8'h20, 8'h60, 0};
    tbl[4] = '{1, 2, 0,     8'h9A, 8'hFF, 8'h9A, 1};
    tbl[5] = '{0, 0, 0,     0,     8'h00, 8'h00, 0};
    tbl[6] = '{0, 0, 0,     0,     8'h7F, 8'h00, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    model_reset();
    #3;
    check_zero("por");
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table; non-sof rows carry junk config that must be ignored
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sof)
        drive(1, 1, tbl[i].sel, tbl[i].val, tbl[i].thr, tbl[i].b, 1);
      else
        drive(1, 0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), tbl[i].b, 1);
      cycle();
      chk("tbl_out", px.out_byte, tbl[i].exp_out);
      chk("tbl_sof", px.out_sof, tbl[i].exp_sof);
`ifdef IMG_DECR_SAT_STATS_EN
      if (i == 3) chk("tbl_sat", sat_count, 1);
`endif
    end

    // Full inverted frame
    do_reset();
    eofs = 0; errs = 0;
    for (int k = 0; k < FP; k++) begin
      drive(1, k == 0, 3, $urandom_range(0, 255), $urandom_range(0, 255), k % 256, 1);
      cycle();
      chk("inv_byte", px.out_byte, 255 - (k % 256));
      if (px.out_eof) eofs++;
      if (frame_err) errs++;
    end
    chk("frame_eof_count", eofs, 1);
    chk("frame_err_count", errs, 0);
    drive(1, 0, 0, 0, 0, 8'h11, 1);
    cycle();
    chk("late_err", frame_err, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();

    // Backpressure hold for 5 cycles
    drive(1, 1, 0, 8'h10, 0, 8'h80, 1);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 8'h40 + k, 1);
      cycle();
    end
    held = int'(px.out_byte);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 8'hA0 + k, 0);
      cycle();
      chk("stall_hold", px.out_byte, held);
      chk("stall_valid", px.out_valid, 1);
      chk("stall_ready", px.in_ready, 0);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 0, 0, 8'hC0 + k, 1);
      cycle();
    end

    // Sof at pixel 100 restarts the frame
    do_reset();
    drive(1, 1, 0, 5, 0, 8'h30, 1);
    cycle();
    for (int k = 1; k < 100; k++) begin
      drive(1, 0, 0, 0, 0, k, 1);
      cycle();
    end
    drive(1, 1, 1, 3, 0, 8'h10, 1);
    cycle();
    chk("resync_err", frame_err, 1);
    chk("resync_cfg", px.out_byte, 8'h13);
    found = 0; n = 0;
    for (int k = 1; k <= FP + 10 && !found; k++) begin
      drive(1, 0, 0, 0, 0, k % 256, 1);
      cycle();
      if (px.out_valid && px.out_eof) begin found = 1; n = k; end
    end
    chk("eof_found", found, 1);
    chk("eof_pos", n, FP - 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, k == 0, 2, 0, 8'h55, 8'hFF, 1);
      cycle();
    end
    chk("pre_rst_valid", px.out_valid, 1);
    do_reset();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit sof;
      sof = ($urandom_range(0, 199) == 0) && (m_cnt != FP - 1);
      drive($urandom_range(0, 3) != 0, sof, $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/img_decr_stream.md
Name: img_decr_stream

Overview:
- Streaming pixel decoder: undoes the per-pixel brighten/darken/threshold/invert transforms applied by the image encoder.
- Sits on the pixel path after the encoder's output, between a valid/ready source and a valid/ready sink.
- Latches its decode configuration per frame, counts pixels, flags frame boundaries and framing errors.
- Registered single-stage pipeline with full backpressure support.

Parameters:
FRAME_PIXELS, 4096, pixels per frame (64x64 default); must be >=2
CNT_W, 12, pixel counter width; must satisfy 2**CNT_W >= FRAME_PIXELS

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  source beat valid
in_ready  output  1  decoder can accept a beat
in_byte  input  8  encoded pixel
in_sof  input  1  beat is first pixel of a frame; samples select/value/threshold
select  input  2  decode mode: 00 un-brighten, 01 un-darken, 10 un-threshold, 11 un-invert
value  input  8  offset used by modes 00/01
threshold  input  8  restore level used by mode 10
out_valid  output  1  decoded beat valid
out_ready  input  1  sink accepts beat
out_byte  output  8  decoded pixel
out_sof  output  1  decoded beat is first of frame
out_eof  output  1  decoded beat is last of frame (pixel index FRAME_PIXELS-1)
frame_err  output  1  one-cycle pulse on a framing violation
sat_count  output  16  saturated-pixel count for the current frame (see Optional Feature)

Behaviour:
- Reset (async assert, sync release) sets:
  - out_valid=0, out_byte=0, out_sof=0, out_eof=0, frame_err=0, sat_count=0
  - pixel counter=0
  - config sel_q=2'b11, value_q=0, thr_q=0
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Output holds stable while out_valid && !out_ready.
- Latency:
  - Accepted beat appears on outputs the next cycle.
  - Back-to-back throughput is 1 beat/cycle while out_ready=1.
- Config:
  - On an accepted beat with in_sof=1, sel_q/value_q/thr_q load from select/value/threshold.
  - That same beat is decoded with the new (input-side) config.
  - All other beats use the registered config.
- Decode, 8-bit unsigned, effective config (sel, val, thr):
  - 00: out = (in < val) ? 0 : in - val. Saturating.
  - 01: out = (in > 255 - val) ? 255 : in + val. Saturating.
  - 10: out = (in == 8'hFF) ? thr : 0.
  - 11: out = 255 - in.
- Pixel counter:
  - Increments per accepted beat.
  - On the beat where counter == FRAME_PIXELS-1: out_eof=1 and the counter wraps to 0.
  - An in_sof beat is pixel 0; the counter becomes 1 after it.
- Framing errors (frame_err pulses one cycle, aligned with the offending decoded beat):
  - in_sof=1 with counter != 0: beat is decoded and restarts the frame (counter -> 1).
  - in_sof=0 with counter == 0, i.e. first beat after reset or after eof: beat is decoded with the held config and the counter advances normally.
- Simultaneous eof and sof are impossible by construction; FRAME_PIXELS >= 2.
- Reset mid-frame:
  - Any in-flight output beat is dropped.
  - Counter clears; config returns to reset values.

Optional Feature:
- Macro: IMG_DECR_SAT_STATS_EN.
- Defined:
  - sat_count increments per accepted beat whose mode-00/01 result was clamped (to 0 or 255 respectively).
  - sat_count clears to 0, then counts that beat, on an accepted in_sof beat.
  - sat_count saturates at 16'hFFFF.
- Undefined: sat_count is tied to 0 and no counter logic is built.

Decomposition:
- Package img_pkg:
  - PIX_W=8, PIX_MAX=8'hFF.
  - Mode constants MODE_BRIGHT=2'b00, MODE_DARK=2'b01, MODE_THRESH=2'b10, MODE_INV=2'b11.
  - Shared with the encoder.
- Sub-module img_pix_inv:
  - Purely combinational; takes (sel, val, thr, in_byte) and returns (out_byte, sat).
  - The top keeps the handshake, config registers, counter and stats.

Test Plan:
- Reset then sof beat select=00 value=0x20, in_byte=0x50 then 0x10 -> out_byte 0x30 then 0x00 one cycle after each accept; out_sof=1 on the first only.
- Sof beat select=01 value=0x40, in_byte 0xF0 then 0x20 -> out 0xFF then 0x60; with IMG_DECR_SAT_STATS_EN sat_count=1 after both.
- Sof beat select=10 threshold=0x9A, bytes 0xFF,0x00,0x7F -> 0x9A,0x00,0x00.
- Full FRAME_PIXELS frame with select=11, byte=k mod 256 -> out = 255-(k mod 256), out_eof only on beat 4095, no frame_err; then a non-sof beat -> frame_err pulse.
- Hold out_ready=0 for 5 cycles mid-stream -> out_byte/out_valid stable, in_ready=0, no beats lost or duplicated after release.
- Sof asserted at pixel 100 -> frame_err pulse, config reloaded, eof occurs FRAME_PIXELS-1 beats later; assert rst mid-frame -> all outputs 0 immediately.
